// File: rtl/clic_target_mt.sv
// Multi-target CLIC arbiter: per-target max-tree selection over routed sources,
// priority threshold, and an independent valid/ready/kill handshake per target.
module clic_target_mt #(
    parameter int unsigned N_SOURCE  = 64,
    parameter int unsigned N_TARGET  = 2,
    parameter int unsigned N_PIPE    = 1,
    parameter int unsigned PrioWidth = 8,
    parameter int unsigned ModeWidth = 2,
    parameter int unsigned SrcWidth  = $clog2(N_SOURCE),
    parameter int unsigned TgtWidth  = (N_TARGET > 1) ? $clog2(N_TARGET) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [N_SOURCE-1:0]                  ip_i,
    input  logic [N_SOURCE-1:0]                  ie_i,
    input  logic [N_SOURCE-1:0]                  le_i,
    input  logic [N_SOURCE-1:0]                  shv_i,
    input  logic [N_SOURCE-1:0][PrioWidth-1:0]   prio_i,
    input  logic [N_SOURCE-1:0][ModeWidth-1:0]   mode_i,
    input  logic [N_SOURCE-1:0][TgtWidth-1:0]    target_i,
    input  logic [N_TARGET-1:0][PrioWidth-1:0]   thresh_i,
    output logic [N_SOURCE-1:0]                  claim_o,
    output logic [N_TARGET-1:0]                  irq_valid_o,
    input  logic [N_TARGET-1:0]                  irq_ready_i,
    output logic [N_TARGET-1:0][SrcWidth-1:0]    irq_id_o,
    output logic [N_TARGET-1:0][PrioWidth-1:0]   irq_prio_o,
    output logic [N_TARGET-1:0][ModeWidth-1:0]   irq_mode_o,
    output logic [N_TARGET-1:0]                  irq_shv_o,
    output logic [N_TARGET-1:0]                  irq_kill_req_o,
    input  logic [N_TARGET-1:0]                  irq_kill_ack_i
);

    localparam int unsigned KeyWidth  = ModeWidth + PrioWidth;
    localparam int unsigned NumLeaves = 1 << SrcWidth;
    localparam int unsigned NumNodes  = 2 * NumLeaves - 1;

    typedef enum logic [1:0] {
        StIdle,
        StAck,
        StClaim
    } state_e;

    // Heap-ordered tree nodes per target: node 0 is the root, leaves start at NumLeaves-1.
    logic [N_TARGET-1:0][NumNodes-1:0]               node_valid;
    logic [N_TARGET-1:0][NumNodes-1:0][SrcWidth-1:0] node_id;
    logic [N_TARGET-1:0][NumNodes-1:0][KeyWidth-1:0] node_key;

    logic [N_TARGET-1:0]               tree_valid;
    logic [N_TARGET-1:0][SrcWidth-1:0] tree_id;
    logic [N_TARGET-1:0][KeyWidth-1:0] tree_key;

    logic [N_TARGET-1:0]               root_valid;
    logic [N_TARGET-1:0][SrcWidth-1:0] root_id;
    logic [N_TARGET-1:0][KeyWidth-1:0] root_key;

    state_e                             state_q [N_TARGET];
    state_e                             state_d [N_TARGET];
    logic [N_TARGET-1:0]                valid_q, valid_d;
    logic [N_TARGET-1:0]                kill_q, kill_d;
    logic [N_TARGET-1:0]                shv_q, shv_d;
    logic [N_TARGET-1:0][SrcWidth-1:0]  id_q, id_d;
    logic [N_TARGET-1:0][PrioWidth-1:0] prio_q, prio_d;
    logic [N_TARGET-1:0][ModeWidth-1:0] mode_q, mode_d;

    logic [N_TARGET-1:0]                withdraw;
    logic [N_TARGET-1:0][KeyWidth-1:0]  lat_key;

    // Max-tree per target; ties keep the left (lower-id) child.
    always_comb begin
        node_valid = '0;
        node_id    = '0;
        node_key   = '0;
        tree_valid = '0;
        tree_id    = '0;
        tree_key   = '0;
        for (int unsigned t = 0; t < N_TARGET; t++) begin
            for (int unsigned s = 0; s < N_SOURCE; s++) begin
                node_valid[t][NumLeaves-1+s] = ip_i[s] & ie_i[s]
                                             & (target_i[s] == TgtWidth'(t))
                                             & (prio_i[s] > thresh_i[t]);
                node_id[t][NumLeaves-1+s]    = SrcWidth'(s);
                node_key[t][NumLeaves-1+s]   = {mode_i[s], prio_i[s]};
            end
            for (int n = int'(NumLeaves) - 2; n >= 0; n--) begin
                if (node_valid[t][2*n+1] &
                    (~node_valid[t][2*n+2] | (node_key[t][2*n+1] >= node_key[t][2*n+2]))) begin
                    node_valid[t][n] = node_valid[t][2*n+1];
                    node_id[t][n]    = node_id[t][2*n+1];
                    node_key[t][n]   = node_key[t][2*n+1];
                end else begin
                    node_valid[t][n] = node_valid[t][2*n+2];
                    node_id[t][n]    = node_id[t][2*n+2];
                    node_key[t][n]   = node_key[t][2*n+2];
                end
            end
            tree_valid[t] = node_valid[t][0];
            tree_id[t]    = node_id[t][0];
            tree_key[t]   = node_key[t][0];
        end
    end

    if (N_PIPE != 0) begin : g_pipe
        // Root register stage between the max-trees and the handshake FSMs.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                root_valid <= '0;
                root_id    <= '0;
                root_key   <= '0;
            end else begin
                root_valid <= tree_valid;
                root_id    <= tree_id;
                root_key   <= tree_key;
            end
        end
    end else begin : g_no_pipe
        assign root_valid = tree_valid;
        assign root_id    = tree_id;
        assign root_key   = tree_key;
    end

    // Withdraw condition and latched rank of the offered source, per target.
    always_comb begin
        withdraw = '0;
        lat_key  = '0;
        for (int unsigned t = 0; t < N_TARGET; t++) begin
            withdraw[t] = (~le_i[id_q[t]] & (~ip_i[id_q[t]] | ~ie_i[id_q[t]]))
                        | (target_i[id_q[t]] != TgtWidth'(t));
            lat_key[t]  = {mode_q[t], prio_q[t]};
        end
    end

    // Handshake FSMs: next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        kill_d  = kill_q;
        shv_d   = shv_q;
        id_d    = id_q;
        prio_d  = prio_q;
        mode_d  = mode_q;
        for (int unsigned t = 0; t < N_TARGET; t++) begin
            case (state_q[t])
                StIdle: begin
                    if (root_valid[t]) begin
                        state_d[t] = StAck;
                        valid_d[t] = 1'b1;
                        kill_d[t]  = 1'b0;
                        id_d[t]    = root_id[t];
                        prio_d[t]  = root_key[t][PrioWidth-1:0];
                        mode_d[t]  = root_key[t][KeyWidth-1:PrioWidth];
                        shv_d[t]   = shv_i[root_id[t]];
                    end else begin
                        valid_d[t] = 1'b0;
                        kill_d[t]  = 1'b0;
                        id_d[t]    = '0;
                        prio_d[t]  = '0;
                        mode_d[t]  = '0;
                        shv_d[t]   = 1'b0;
                    end
                end
                StAck: begin
                    if (withdraw[t]) begin
                        state_d[t] = StIdle;
                        valid_d[t] = 1'b0;
                        kill_d[t]  = 1'b0;
                    end else if (valid_q[t] & irq_ready_i[t]) begin
                        // Accept wins over a same-cycle kill acknowledge.
                        state_d[t] = StClaim;
                        valid_d[t] = 1'b0;
                        kill_d[t]  = 1'b0;
                    end else if (kill_q[t] & irq_kill_ack_i[t]) begin
                        state_d[t] = StIdle;
                        valid_d[t] = 1'b0;
                        kill_d[t]  = 1'b0;
                    end else if (root_valid[t] & (root_key[t] > lat_key[t])) begin
                        kill_d[t] = 1'b1;
                    end
                end
                StClaim: begin
                    state_d[t] = StIdle;
                end
                default: begin
                    state_d[t] = StIdle;
                    valid_d[t] = 1'b0;
                    kill_d[t]  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned t = 0; t < N_TARGET; t++) begin
                state_q[t] <= StIdle;
            end
            valid_q <= '0;
            kill_q  <= '0;
            shv_q   <= '0;
            id_q    <= '0;
            prio_q  <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            kill_q  <= kill_d;
            shv_q   <= shv_d;
            id_q    <= id_d;
            prio_q  <= prio_d;
            mode_q  <= mode_d;
        end
    end

    // One-cycle claim pulse per target in CLAIM, merged across targets.
    always_comb begin
        claim_o = '0;
        for (int unsigned t = 0; t < N_TARGET; t++) begin
            if (state_q[t] == StClaim) begin
                claim_o[id_q[t]] = 1'b1;
            end
        end
    end

    assign irq_valid_o    = valid_q;
    assign irq_kill_req_o = kill_q;
    assign irq_id_o       = id_q;
    assign irq_prio_o     = prio_q;
    assign irq_mode_o     = mode_q;
    assign irq_shv_o      = shv_q;

endmodule

// File: tb/tb_clic_target_mt.sv
// Scoreboard bench for clic_target_mt: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_clic_target_mt;

    localparam int NS    = 16;
    localparam int NT    = 3;
    localparam int NPIPE = 1;
    localparam int SW    = 4;
    localparam int TW    = 2;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [NS-1:0]        ip, ie, le, shv;
    logic [NS-1:0][7:0]   prio;
    logic [NS-1:0][1:0]   mode;
    logic [NS-1:0][TW-1:0] tgt;
    logic [NT-1:0][7:0]   thresh;
    logic [NT-1:0]        ready, kack;

    logic [NS-1:0]        claim_o;
    logic [NT-1:0]        irq_valid_o;
    logic [NT-1:0][SW-1:0] irq_id_o;
    logic [NT-1:0][7:0]   irq_prio_o;
    logic [NT-1:0][1:0]   irq_mode_o;
    logic [NT-1:0]        irq_shv_o;
    logic [NT-1:0]        irq_kill_req_o;

    int checks   = 0;
    int failures = 0;

    clic_target_mt #(
        .N_SOURCE (NS),
        .N_TARGET (NT),
        .N_PIPE   (NPIPE),
        .PrioWidth(8),
        .ModeWidth(2)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .ip_i          (ip),
        .ie_i          (ie),
        .le_i          (le),
        .shv_i         (shv),
        .prio_i        (prio),
        .mode_i        (mode),
        .target_i      (tgt),
        .thresh_i      (thresh),
        .claim_o       (claim_o),
        .irq_valid_o   (irq_valid_o),
        .irq_ready_i   (ready),
        .irq_id_o      (irq_id_o),
        .irq_prio_o    (irq_prio_o),
        .irq_mode_o    (irq_mode_o),
        .irq_shv_o     (irq_shv_o),
        .irq_kill_req_o(irq_kill_req_o),
        .irq_kill_ack_i(kack)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [NT-1:0]         valid;
        logic [NT-1:0]         kill;
        logic [NT-1:0]         shv;
        logic [NT-1:0][SW-1:0] id;
        logic [NT-1:0][7:0]    prio;
        logic [NT-1:0][1:0]    mode;
        logic [NS-1:0]         claim;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: per target, an offer phase (0 none, 1 offered, 2 claimed).
    int m_phase [NT];
    bit m_valid [NT];
    bit m_kill  [NT];
    bit m_shv   [NT];
    int m_id    [NT];
    int m_key   [NT];
    bit r_v     [NT];
    int r_id    [NT];
    int r_key   [NT];

    task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] at %0t: got 0x%0h expected 0x%0h", name, t, $time, act, exp);
        end
    endtask

    // Highest-ranked eligible source for target t, by linear scan.
    function automatic void best(input int t, output bit f, output int id, output int key);
        int k;
        f = 1'b0; id = 0; key = 0;
        for (int s = 0; s < NS; s++) begin
            if (ip[s] && ie[s] && int'(tgt[s]) == t && prio[s] > thresh[t]) begin
                k = int'(mode[s]) * 256 + int'(prio[s]);
                if (!f || k > key) begin
                    f = 1'b1; id = s; key = k;
                end
            end
        end
    endfunction

    function automatic void model_reset();
        for (int t = 0; t < NT; t++) begin
            m_phase[t] = 0; m_valid[t] = 0; m_kill[t] = 0; m_shv[t] = 0;
            m_id[t] = 0; m_key[t] = 0; r_v[t] = 0; r_id[t] = 0; r_key[t] = 0;
        end
    endfunction

    // Advance the model one clock and queue the outputs expected after this edge.
    always @(posedge clk_i or negedge rst_ni) begin : model_step
        bit   cv [NT];
        int   cid[NT];
        int   ck [NT];
        int   s;
        exp_t e;
        if (!rst_ni) begin
            model_reset();
            sb_q.delete();
        end else begin
            for (int t = 0; t < NT; t++) begin
                if (NPIPE != 0) begin
                    cv[t] = r_v[t]; cid[t] = r_id[t]; ck[t] = r_key[t];
                end else begin
                    best(t, cv[t], cid[t], ck[t]);
                end
            end
            for (int t = 0; t < NT; t++) begin
                if (m_phase[t] == 0) begin
                    if (cv[t]) begin
                        m_id[t] = cid[t]; m_key[t] = ck[t]; m_shv[t] = shv[cid[t]];
                        m_valid[t] = 1; m_kill[t] = 0; m_phase[t] = 1;
                    end
                end else if (m_phase[t] == 1) begin
                    s = m_id[t];
                    if ((!le[s] && (!ip[s] || !ie[s])) || int'(tgt[s]) != t) begin
                        m_valid[t] = 0; m_kill[t] = 0; m_phase[t] = 0;
                    end else if (ready[t]) begin
                        m_valid[t] = 0; m_kill[t] = 0; m_phase[t] = 2;
                    end else if (m_kill[t] && kack[t]) begin
                        m_valid[t] = 0; m_kill[t] = 0; m_phase[t] = 0;
                    end else if (cv[t] && ck[t] > m_key[t]) begin
                        m_kill[t] = 1;
                    end
                end else begin
                    m_phase[t] = 0;
                end
            end
            if (NPIPE != 0) begin
                for (int t = 0; t < NT; t++) best(t, r_v[t], r_id[t], r_key[t]);
            end
            e = '0;
            for (int t = 0; t < NT; t++) begin
                e.valid[t] = m_valid[t];
                e.kill[t]  = m_kill[t];
                e.shv[t]   = m_shv[t];
                e.id[t]    = SW'(m_id[t]);
                e.prio[t]  = 8'(m_key[t] % 256);
                e.mode[t]  = 2'(m_key[t] / 256);
                if (m_phase[t] == 2) e.claim[m_id[t]] = 1'b1;
            end
            sb_q.push_back(e);
        end
    end

    // Monitor: compare DUT outputs with the next queued expectation.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (!rst_ni) begin
            chk("rst_valid", 0, 32'(irq_valid_o), 32'd0);
            chk("rst_kill", 0, 32'(irq_kill_req_o), 32'd0);
            chk("rst_claim", 0, 32'(claim_o), 32'd0);
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("claim", 0, 32'(claim_o), 32'(e.claim));
            for (int t = 0; t < NT; t++) begin
                chk("valid", t, 32'(irq_valid_o[t]), 32'(e.valid[t]));
                chk("kill", t, 32'(irq_kill_req_o[t]), 32'(e.kill[t]));
                if (e.valid[t]) begin
                    chk("id", t, 32'(irq_id_o[t]), 32'(e.id[t]));
                    chk("prio", t, 32'(irq_prio_o[t]), 32'(e.prio[t]));
                    chk("mode", t, 32'(irq_mode_o[t]), 32'(e.mode[t]));
                    chk("shv", t, 32'(irq_shv_o[t]), 32'(e.shv[t]));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic clear_all();
        ip = '0; ie = '0; le = '0; shv = '0; prio = '0; mode = '0; tgt = '0;
        thresh = '0; ready = '0; kack = '0;
        tick(4);
    endtask

    task automatic set_src(input int s, input int p, input int m, input int t, input bit edge_trig);
        ip[s] = 1'b1; ie[s] = 1'b1; le[s] = edge_trig;
        prio[s] = 8'(p); mode[s] = 2'(m); tgt[s] = TW'(t); shv[s] = 1'(s % 2);
    endtask

    initial begin
        bit seen;
        rst_ni = 1'b0;
        ip = '0; ie = '0; le = '0; shv = '0; prio = '0; mode = '0; tgt = '0;
        thresh = '0; ready = '0; kack = '0;
        tick(3);
        rst_ni = 1'b1;
        tick(2);

        // Basic offer, latency and claim.
        ready[0] = 1'b1;
        set_src(5, 3, 3, 0, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("lat_edge1", 0, 32'(irq_valid_o[0]), 32'd0);
        @(negedge clk_i);
        chk("lat_edge2", 0, 32'(irq_valid_o[0]), 32'd1);
        chk("lat_id", 0, 32'(irq_id_o[0]), 32'd5);
        chk("lat_prio", 0, 32'(irq_prio_o[0]), 32'd3);
        @(negedge clk_i);
        chk("claim5", 0, 32'(claim_o), 32'h0020);
        tick(4);
        clear_all();

        // Tie on equal keys, then preemption by a raised priority.
        set_src(4, 7, 3, 0, 1'b0);
        set_src(9, 7, 3, 0, 1'b0);
        tick(4);
        chk("tie_id", 0, 32'(irq_id_o[0]), 32'd4);
        prio[9] = 8'd8;
        tick(3);
        chk("preempt_kill", 0, 32'(irq_kill_req_o[0]), 32'd1);
        kack[0] = 1'b1;
        tick(1);
        kack[0] = 1'b0;
        tick(4);
        chk("preempt_id", 0, 32'(irq_id_o[0]), 32'd9);
        clear_all();

        // Threshold on target 1.
        thresh[1] = 8'd10;
        set_src(2, 10, 1, 1, 1'b0);
        tick(4);
        chk("thresh_eq", 1, 32'(irq_valid_o[1]), 32'd0);
        prio[2] = 8'd11;
        tick(4);
        chk("thresh_gt", 1, 32'(irq_valid_o[1]), 32'd1);
        clear_all();

        // Level withdraw versus edge hold.
        set_src(7, 5, 2, 0, 1'b0);
        tick(4);
        ip[7] = 1'b0;
        tick(4);
        le[7] = 1'b1;
        ip[7] = 1'b1;
        tick(4);
        ip[7] = 1'b0;
        tick(4);
        chk("edge_hold", 0, 32'(irq_valid_o[0]), 32'd1);
        ready[0] = 1'b1;
        tick(3);
        clear_all();

        // Two targets claim in the same cycle.
        set_src(1, 4, 1, 0, 1'b0);
        set_src(3, 6, 2, 1, 1'b0);
        tick(4);
        ready = 3'b011;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (claim_o != '0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("pair_seen", 0, 32'(seen), 32'd1);
        chk("pair_claim", 0, 32'(claim_o), 32'h000A);
        tick(1);
        clear_all();

        // Asynchronous reset while a kill request is outstanding.
        set_src(4, 7, 3, 0, 1'b0);
        set_src(9, 7, 3, 0, 1'b0);
        tick(4);
        prio[9] = 8'd8;
        tick(3);
        chk("rst_pre_kill", 0, 32'(irq_kill_req_o[0]), 32'd1);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("async_valid", 0, 32'(irq_valid_o), 32'd0);
        chk("async_kill", 0, 32'(irq_kill_req_o), 32'd0);
        chk("async_id", 0, 32'(irq_id_o), 32'd0);
        chk("async_claim", 0, 32'(claim_o), 32'd0);
        tick(2);
        rst_ni = 1'b1;
        tick(3);
        chk("reoffer", 0, 32'(irq_valid_o[0]), 32'd1);
        clear_all();

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            int s;
            s = int'($urandom_range(0, NS - 1));
            case ($urandom_range(0, 3))
                0: begin
                    ip[s] = 1'($urandom); ie[s] = 1'($urandom | $urandom);
                    le[s] = 1'($urandom); shv[s] = 1'($urandom);
                    prio[s] = 8'($urandom_range(0, 15)); mode[s] = 2'($urandom);
                    tgt[s] = TW'($urandom);
                end
                1: ip[s] = ~ip[s];
                2: prio[s] = 8'($urandom_range(0, 15));
                default: ;
            endcase
            ready = NT'($urandom & $urandom & $urandom);
            kack  = NT'($urandom);
            if ($urandom_range(0, 31) == 0) thresh[$urandom_range(0, NT - 1)] = 8'($urandom_range(0, 6));
            tick(1);
        end
        clear_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
